// File: rtl/pc_16b_branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_16b_branch_pkg
//  Description : Shared types and constants for the 6502 program counter
//                (FSM state encoding, branch fixup direction, reset vector).
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_16b_branch_pkg;

    // Sequencer states: IDLE accepts commands, FIXUP corrects PCH after a
    // branch that crossed a page boundary.
    typedef enum logic [0:0] {
        PC_ST_IDLE  = 1'b0,
        PC_ST_FIXUP = 1'b1
    } pc_state_t;

    // Direction of the pending PCH correction.
    typedef enum logic [0:0] {
        PC_DIR_UP   = 1'b0,
        PC_DIR_DOWN = 1'b1
    } pc_dir_t;

    // Low byte address of the 6502 reset vector.
    localparam logic [15:0] c_PC_RESET_VEC = 16'hFFFC;

endpackage : pc_16b_branch_pkg
`default_nettype wire

// File: rtl/pc_16b_branch_adder_8b_carry.sv
`default_nettype none
// ============================================================================
//  Module      : adder_8b_carry
//  Description : 8-bit ripple adder with carry-in and carry-out. Used for the
//                PCL branch add and for the +1/-1 PCH page fixup.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_8b_carry (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    // Nine-bit sum so the carry out of bit 7 is captured explicitly.
    always_comb begin
        {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
    end

endmodule : adder_8b_carry
`default_nettype wire

// File: rtl/pc_16b_branch.sv
`default_nettype none
// ============================================================================
//  Module      : pc_16b_branch
//  Description : 16-bit 6502 program counter with reset vector, increment,
//                byte loads and signed relative branch. A branch that crosses
//                a page takes one extra FIXUP cycle to correct PCH, exposing
//                the intermediate {old PCH, new PCL} address as real hardware.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_16b_branch
    import pc_16b_branch_pkg::*;
#(
    parameter logic [15:0] PC_RESET = c_PC_RESET_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic        branch,
    input  logic [7:0]  data_in,
    output logic [15:0] pc,
    output logic        busy,
    output logic        page_cross
);

    pc_state_t   r_state;
    pc_dir_t     r_dir;
    logic [15:0] r_pc;

    logic        w_fixup;
    logic [7:0]  w_add_a;
    logic [7:0]  w_add_b;
    logic [7:0]  w_add_sum;
    logic        w_add_cout;
    logic        w_cross;

    // One adder is shared: PCL + offset while idle, PCH +/- 1 during FIXUP.
    // Subtracting one is done by adding 8'hFF and discarding the carry.
    always_comb begin
        w_fixup = (r_state == PC_ST_FIXUP);
        w_add_a = w_fixup ? r_pc[15:8] : r_pc[7:0];
        if (w_fixup) begin
            w_add_b = (r_dir == PC_DIR_DOWN) ? 8'hFF : 8'h01;
        end else begin
            w_add_b = data_in;
        end
    end

    adder_8b_carry u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // A positive offset crosses on carry out; a negative offset (sign-extended
    // to 0xFF in the high byte) crosses when there is no carry out.
    always_comb begin
        w_cross = data_in[7] ? ~w_add_cout : w_add_cout;
    end

    // PC register and sequencer: loads beat branch, branch beats increment;
    // FIXUP ignores every input other than rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= PC_RESET;
            r_state <= PC_ST_IDLE;
            r_dir   <= PC_DIR_UP;
        end else begin
            case (r_state)
                PC_ST_IDLE: begin
                    if (load_lo || load_hi) begin
                        if (load_lo) r_pc[7:0]  <= data_in;
                        if (load_hi) r_pc[15:8] <= data_in;
                    end else if (branch) begin
                        r_pc[7:0] <= w_add_sum;
                        if (w_cross) begin
                            r_state <= PC_ST_FIXUP;
                            r_dir   <= data_in[7] ? PC_DIR_DOWN : PC_DIR_UP;
                        end
                    end else if (inc) begin
                        r_pc <= r_pc + 16'd1;
                    end
                end
                PC_ST_FIXUP: begin
                    r_pc[15:8] <= w_add_sum;
                    r_state    <= PC_ST_IDLE;
                end
                default: begin
                    r_state <= PC_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from flops; busy and page_cross are Moore outputs.
    always_comb begin
        pc         = r_pc;
        busy       = (r_state == PC_ST_FIXUP);
        page_cross = (r_state == PC_ST_FIXUP);
    end

endmodule : pc_16b_branch
`default_nettype wire

// File: tb/tb_pc_16b_branch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_16b_branch
//  Description : Directed self-checking bench for pc_16b_branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_16b_branch;

    logic        clk;
    logic        rst;
    logic        inc;
    logic        load_lo;
    logic        load_hi;
    logic        branch;
    logic [7:0]  data_in;
    logic [15:0] pc;
    logic        busy;
    logic        page_cross;

    int n_checks;
    int n_fail;

    pc_16b_branch #(.PC_RESET(16'hFFFC)) dut (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .load_lo    (load_lo),
        .load_hi    (load_hi),
        .branch     (branch),
        .data_in    (data_in),
        .pc         (pc),
        .busy       (busy),
        .page_cross (page_cross)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inc = 0; load_lo = 0; load_hi = 0; branch = 0; data_in = 8'h00;
    endtask

    // Put an arbitrary value into pc with two single-byte loads.
    task automatic set_pc(input logic [15:0] v);
        idle_inputs();
        load_lo = 1; data_in = v[7:0];  tick();
        load_lo = 0; load_hi = 1; data_in = v[15:8]; tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); rst = 0;
        n_checks++; if (pc !== 16'hFFFC) begin n_fail++; $display("FAIL reset_pc got %h exp FFFC", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL reset_pcross got %b exp 0", page_cross); end
        inc = 1; tick();
        n_checks++; if (pc !== 16'hFFFD) begin n_fail++; $display("FAIL inc1 got %h exp FFFD", pc); end
        tick(); tick();
        n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL inc3 got %h exp FFFF", pc); end
        tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap got %h exp 0000", pc); end
        inc = 0; tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL hold got %h exp 0000", pc); end
    endtask

    task automatic test_loads();
        idle_inputs();
        load_lo = 1; data_in = 8'h34; tick();
        n_checks++; if (pc !== 16'h0034) begin n_fail++; $display("FAIL load_lo got %h exp 0034", pc); end
        load_lo = 0; load_hi = 1; data_in = 8'h12; tick();
        n_checks++; if (pc !== 16'h1234) begin n_fail++; $display("FAIL load_hi got %h exp 1234", pc); end
        load_hi = 0; load_lo = 1; inc = 1; data_in = 8'hAA; tick();
        n_checks++; if (pc !== 16'h12AA) begin n_fail++; $display("FAIL load_over_inc got %h exp 12AA", pc); end
        load_hi = 1; branch = 1; data_in = 8'h5A; tick();
        n_checks++; if (pc !== 16'h5A5A) begin n_fail++; $display("FAIL load_both got %h exp 5A5A", pc); end
        idle_inputs();
    endtask

    task automatic test_branch_no_cross();
        set_pc(16'h1210);
        branch = 1; inc = 1; data_in = 8'h05; tick();
        branch = 0; inc = 0;
        n_checks++; if (pc !== 16'h1215) begin n_fail++; $display("FAIL br_fwd got %h exp 1215", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL br_fwd_busy got %b exp 0", busy); end
        set_pc(16'h1210);
        branch = 1; data_in = 8'hF0; tick();
        branch = 0;
        n_checks++; if (pc !== 16'h1200) begin n_fail++; $display("FAIL br_back got %h exp 1200", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL br_back_busy got %b exp 0", busy); end
        tick();
        n_checks++; if (pc !== 16'h1200) begin n_fail++; $display("FAIL br_back_hold got %h exp 1200", pc); end
    endtask

    task automatic test_fwd_cross();
        set_pc(16'h12F0);
        branch = 1; data_in = 8'h20; tick();
        branch = 0; inc = 1; load_lo = 1; data_in = 8'h77;
        n_checks++; if (pc !== 16'h1210) begin n_fail++; $display("FAIL fx_mid got %h exp 1210", pc); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fx_busy got %b exp 1", busy); end
        n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL fx_pcross got %b exp 1", page_cross); end
        tick();
        idle_inputs();
        n_checks++; if (pc !== 16'h1310) begin n_fail++; $display("FAIL fx_final got %h exp 1310", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fx_busy_end got %b exp 0", busy); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL fx_pcross_end got %b exp 0", page_cross); end
    endtask

    task automatic test_bwd_cross_wrap();
        set_pc(16'h0005);
        branch = 1; data_in = 8'hFA; tick();
        branch = 0;
        n_checks++; if (pc !== 16'h00FF) begin n_fail++; $display("FAIL bx_mid got %h exp 00FF", pc); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bx_busy got %b exp 1", busy); end
        tick();
        n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("FAIL bx_final got %h exp FFFF", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bx_busy_end got %b exp 0", busy); end
    endtask

    // Branch issued immediately after a fixup, crossing up through FFxx -> 00xx.
    task automatic test_back_to_back();
        branch = 1; data_in = 8'h01; tick();
        branch = 0;
        n_checks++; if (pc !== 16'hFF00) begin n_fail++; $display("FAIL b2b_mid got %h exp FF00", pc); end
        n_checks++; if (page_cross !== 1'b1) begin n_fail++; $display("FAIL b2b_pcross got %b exp 1", page_cross); end
        tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL b2b_final got %h exp 0000", pc); end
    endtask

    task automatic test_reset_mid_fixup();
        set_pc(16'h12F0);
        branch = 1; data_in = 8'h20; tick();
        branch = 0; rst = 1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmf_busy_pre got %b exp 1", busy); end
        tick();
        rst = 0;
        n_checks++; if (pc !== 16'hFFFC) begin n_fail++; $display("FAIL rmf_pc got %h exp FFFC", pc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy got %b exp 0", busy); end
        n_checks++; if (page_cross !== 1'b0) begin n_fail++; $display("FAIL rmf_pcross got %b exp 0", page_cross); end
        tick();
        n_checks++; if (pc !== 16'hFFFC) begin n_fail++; $display("FAIL rmf_hold got %h exp FFFC", pc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1;
        idle_inputs();
        test_reset();
        test_loads();
        test_branch_no_cross();
        test_fwd_cross();
        test_bwd_cross_wrap();
        test_back_to_back();
        test_reset_mid_fixup();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_16b_branch
`default_nettype wire
